// File: rtl/hex_token_parser.sv
`default_nettype none
// ============================================================================
//  Module   : hex_token_parser
//  Purpose  : Parses a UART Rx character stream into hexadecimal tokens.
//             Digits accumulate into a 32-bit value until a terminator
//             (space, CR, LF or comma) completes the token. Illegal
//             characters and digit overflow raise a one-cycle error pulse,
//             and the rest of the token is then skipped.
//  Revision : 1.0  initial release
// ============================================================================
module hex_token_parser #(
   parameter int MAX_DIGITS = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        iVALID,
   input  logic [7:0]  iCHAR,
   output logic        oREADY,
   output logic [31:0] oVALUE,
   output logic [3:0]  oDIGITS,
   output logic        oDONE,
   output logic        oERR,
   output logic        oOVF
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2,
      SKIP  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] acc, acc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        err_nxt;
   logic        ovf_nxt;
   logic        load_out;
   logic        accept;
   logic        is_digit;
   logic        is_term;
   logic [3:0]  nibble;

   // oREADY is a register that is low exactly while in DONE
   assign accept = iVALID & oREADY;

   // Character classification and hex digit decode
   always_comb begin
      is_digit = 1'b0;
      is_term  = 1'b0;
      nibble   = 4'd0;
      if (iCHAR >= 8'h30 && iCHAR <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = iCHAR[3:0];
      end else if ((iCHAR >= 8'h41 && iCHAR <= 8'h46) ||
                   (iCHAR >= 8'h61 && iCHAR <= 8'h66)) begin
         is_digit = 1'b1;
         nibble   = iCHAR[3:0] + 4'd9;
      end else if (iCHAR == 8'h20 || iCHAR == 8'h0D ||
                   iCHAR == 8'h0A || iCHAR == 8'h2C) begin
         is_term  = 1'b1;
      end
   end

   // Next-state, accumulator and pulse decisions
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      ovf_nxt   = 1'b0;
      load_out  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_digit) begin
                  acc_nxt   = {28'd0, nibble};
                  cnt_nxt   = 4'd1;
                  state_nxt = ACCUM;
               end else if (!is_term) begin
                  err_nxt   = 1'b1;
                  state_nxt = SKIP;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               if (is_digit) begin
                  if (cnt == MAX_CNT) begin
                     err_nxt   = 1'b1;
                     ovf_nxt   = 1'b1;
                     state_nxt = SKIP;
                  end else begin
                     // count < MAX_DIGITS keeps bits above 4*MAX_DIGITS zero
                     acc_nxt = {acc[27:0], nibble};
                     cnt_nxt = cnt + 4'd1;
                  end
               end else if (is_term) begin
                  load_out  = 1'b1;
                  state_nxt = DONE;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = SKIP;
               end
            end
         end
         DONE: begin
            acc_nxt   = 32'd0;
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
         end
         SKIP: begin
            acc_nxt = 32'd0;
            cnt_nxt = 4'd0;
            if (accept && is_term) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, accumulator and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         acc     <= 32'd0;
         cnt     <= 4'd0;
         oREADY  <= 1'b1;
         oVALUE  <= 32'd0;
         oDIGITS <= 4'd0;
         oDONE   <= 1'b0;
         oERR    <= 1'b0;
         oOVF    <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         oREADY  <= (state_nxt != DONE);
         oDONE   <= (state_nxt == DONE);
         oERR    <= err_nxt;
         oOVF    <= ovf_nxt;
         if (load_out) begin
            oVALUE  <= acc;
            oDIGITS <= cnt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_token_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_token_parser
//  Purpose  : Self-checking bench for hex_token_parser. Expected pulses are
//             queued before the causing character is sent and checked when
//             the DUT pulses oDONE or oERR.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hex_token_parser;

   logic        CLK;
   logic        RST_N;
   logic        iVALID;
   logic [7:0]  iCHAR;
   logic        oREADY;
   logic [31:0] oVALUE;
   logic [3:0]  oDIGITS;
   logic        oDONE;
   logic        oERR;
   logic        oOVF;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;

   typedef struct {
      bit          is_err;
      bit          ovf;
      logic [31:0] value;
      logic [3:0]  digits;
   } exp_t;

   exp_t sb[$];

   hex_token_parser #(.MAX_DIGITS(8)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .iVALID  (iVALID),
      .iCHAR   (iCHAR),
      .oREADY  (oREADY),
      .oVALUE  (oVALUE),
      .oDIGITS (oDIGITS),
      .oDONE   (oDONE),
      .oERR    (oERR),
      .oOVF    (oOVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle counter used to check one-cycle response latency
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_done(input logic [31:0] v, input logic [3:0] d);
      exp_t e;
      e.is_err = 1'b0; e.ovf = 1'b0; e.value = v; e.digits = d;
      sb.push_back(e);
   endtask

   task automatic push_err(input bit ovf);
      exp_t e;
      e.is_err = 1'b1; e.ovf = ovf; e.value = 32'd0; e.digits = 4'd0;
      sb.push_back(e);
   endtask

   // Offer one character and hold it until the DUT accepts it
   task automatic send(input logic [7:0] c);
      int w;
      w = 0;
      @(negedge CLK);
      iVALID = 1'b1;
      iCHAR  = c;
      while (oREADY !== 1'b1 && w < 10) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 10) chk("ready_timeout", 32'(oREADY), 32'd1);
      @(posedge CLK);
      #1;
      last_acc = cyc;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic idle(input int n);
      @(negedge CLK);
      iVALID = 1'b0;
      iCHAR  = 8'h00;
      repeat (n) @(negedge CLK);
   endtask

   // Scoreboard: every pulse must match the oldest queued expectation
   always @(negedge CLK) begin
      if (RST_N && (oDONE || oERR)) begin
         chk("done_err_exclusive", 32'(oDONE & oERR), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, oDONE, oERR}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind_err", 32'(oERR), 32'(e.is_err));
            if (e.is_err) begin
               chk("err_ovf", 32'(oOVF), 32'(e.ovf));
            end else begin
               chk("done_value", oVALUE, e.value);
               chk("done_digits", 32'(oDIGITS), 32'(e.digits));
            end
            chk("pulse_latency", 32'(cyc), 32'(last_acc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N  = 1'b0;
      iVALID = 1'b0;
      iCHAR  = 8'h00;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", 32'(oREADY), 32'd1);
      chk("rst_value", oVALUE, 32'd0);
      chk("rst_digits", 32'(oDIGITS), 32'd0);
      chk("rst_done", 32'(oDONE), 32'd0);
      chk("rst_err", 32'(oERR), 32'd0);
      chk("rst_ovf", 32'(oOVF), 32'd0);
      RST_N = 1'b1;
      idle(2);

      // "1a2F" CR
      send_str("1a2F");
      push_done(32'h0000_1A2F, 4'd4);
      send(8'h0D);
      idle(3);

      // leading/trailing spaces
      send_str("  7");
      push_done(32'h7, 4'd1);
      send(8'h20);
      idle(3);

      // digit overflow, then LF returns to IDLE
      send_str("12345678");
      push_err(1'b1);
      send("9");
      send(8'h0A);
      idle(3);
      chk("ovf_keeps_value", oVALUE, 32'h7);
      chk("ovf_keeps_digits", 32'(oDIGITS), 32'd1);
      push_done(32'h8, 4'd1);
      send("8");
      send(8'h20);
      idle(3);

      // illegal character, rest of token skipped
      send_str("12");
      push_err(1'b0);
      send("G");
      send_str("4,");
      push_done(32'h5, 4'd1);
      send_str("5,");
      idle(3);

      // back-to-back tokens with iVALID held high
      push_done(32'hA, 4'd1);
      send_str("A,");
      @(negedge CLK);
      chk("done_not_ready_1", 32'(oREADY), 32'd0);
      push_done(32'hB, 4'd1);
      send_str("B,");
      @(negedge CLK);
      chk("done_not_ready_2", 32'(oREADY), 32'd0);
      idle(3);

      // reset mid-token abandons it
      send_str("AB");
      @(negedge CLK);
      iVALID = 1'b0;
      #2 RST_N = 1'b0;
      @(negedge CLK);
      chk("midrst_done", 32'(oDONE), 32'd0);
      chk("midrst_err", 32'(oERR), 32'd0);
      chk("midrst_ready", 32'(oREADY), 32'd1);
      chk("midrst_value", oVALUE, 32'd0);
      RST_N = 1'b1;
      idle(2);
      send("C");
      push_done(32'hC, 4'd1);
      send(8'h20);
      idle(4);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
